// File: rtl/inst_fetch_if.sv
// Fetch-side bus between the PC stage (master) and the instruction fetch responder (slave).
// Carries the request address and op, and returns the instruction, its valid pulse and the stall request.
interface inst_fetch_if;
    logic [31:0] addr_i;
    logic [3:0]  ramOp_i;
    logic [31:0] inst_o;
    logic        instValid_o;
    logic        stallReq_o;

    modport master (
        output addr_i,
        output ramOp_i,
        input  inst_o,
        input  instValid_o,
        input  stallReq_o
    );

    modport slave (
        input  addr_i,
        input  ramOp_i,
        output inst_o,
        output instValid_o,
        output stallReq_o
    );
endinterface

// File: rtl/inst_fetch_responder.sv
// IF-stage fetch responder: multi-cycle word read from async SRAM, WAIT_CYCLES+1 cycles to instValid_o.
// Stalls the PC from request until DONE; optional FETCH_ALIGN_CHECK_EN flags misaligned fetches.
module inst_fetch_responder #(
    parameter int ADDR_WIDTH  = 20,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    inst_fetch_if.slave           fetch,
    output logic [ADDR_WIDTH-1:0] sramAddr_o,
    input  logic [31:0]           sramData_i,
    output logic                  sramCe_n,
    output logic                  sramOe_n,
    output logic                  sramWe_n,
    output logic [3:0]            sramBe_n
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic                  excAdel_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_DONE
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_e                  state_q, state_d;
    logic [3:0]              cnt_q, cnt_d;
    logic [31:0]             inst_q;
    logic                    inst_vld_q;
    logic [ADDR_WIDTH-1:0]   sram_addr_q;
    logic                    ce_n_q;
    logic                    oe_n_q;
    logic [3:0]              be_n_q;
    logic                    exc_q;
    logic                    req;
    logic                    misaligned;
    logic                    unused_addr_bits;

    assign req = (fetch.ramOp_i == 4'b1000);

`ifdef FETCH_ALIGN_CHECK_EN
    assign misaligned = (fetch.addr_i[1:0] != 2'b00);
    assign excAdel_o  = exc_q;
`else
    assign misaligned = 1'b0;
`endif
    assign unused_addr_bits = ^{fetch.addr_i[31:ADDR_WIDTH+2], fetch.addr_i[1:0], exc_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    cnt_d   = CNT_LOAD;
                    state_d = misaligned ? S_DONE : S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered alongside the state so they line up with it cycle for cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            inst_q      <= 32'd0;
            inst_vld_q  <= 1'b0;
            sram_addr_q <= '0;
            ce_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            be_n_q      <= 4'b1111;
            exc_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            inst_vld_q <= 1'b0;
            exc_q      <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (req) begin
                        if (misaligned) begin
                            inst_q     <= 32'd0;
                            inst_vld_q <= 1'b1;
                            exc_q      <= 1'b1;
                        end else begin
                            sram_addr_q <= fetch.addr_i[ADDR_WIDTH+1:2];
                            ce_n_q      <= 1'b0;
                            oe_n_q      <= 1'b0;
                            be_n_q      <= 4'b0000;
                        end
                    end
                end
                S_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        inst_q     <= sramData_i;
                        inst_vld_q <= 1'b1;
                        ce_n_q     <= 1'b1;
                        oe_n_q     <= 1'b1;
                        be_n_q     <= 4'b1111;
                    end
                end
                default: ;
            endcase
        end
    end

    // Combinational so the PC holds in the very cycle the request is presented.
    assign fetch.stallReq_o  = !rst && ((state_q == S_IDLE && req) || state_q == S_ACCESS);
    assign fetch.inst_o      = inst_q;
    assign fetch.instValid_o = inst_vld_q;
    assign sramAddr_o        = sram_addr_q;
    assign sramCe_n          = ce_n_q;
    assign sramOe_n          = oe_n_q;
    assign sramWe_n          = 1'b1;
    assign sramBe_n          = be_n_q;

endmodule

// File: tb/tb_inst_fetch_responder.sv
// Directed bench for inst_fetch_responder (ADDR_WIDTH=20, WAIT_CYCLES=2).
// SRAM model returns {12'h3C0, word address}, except word 4 which holds 32'h2402_0005.
module tb_inst_fetch_responder;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] sram_addr;
    logic [31:0] sram_data;
    logic        ce_n, oe_n, we_n;
    logic [3:0]  be_n;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        exc;
`endif
    int total = 0;
    int bad   = 0;

    inst_fetch_if ifc ();

    inst_fetch_responder #(.ADDR_WIDTH(20), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch      (ifc),
        .sramAddr_o (sram_addr),
        .sramData_i (sram_data),
        .sramCe_n   (ce_n),
        .sramOe_n   (oe_n),
        .sramWe_n   (we_n),
        .sramBe_n   (be_n)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .excAdel_o  (exc)
`endif
    );

    always #5 clk = ~clk;

    always_comb begin
        sram_data = 32'hDEAD_BEEF;
        if (!ce_n && !oe_n)
            sram_data = (sram_addr == 20'h4) ? 32'h2402_0005 : {12'h3C0, sram_addr};
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; ifc.ramOp_i = 4'b1000; ifc.addr_i = 32'h10;
        tick; tick; #1;
        total++; if (ifc.stallReq_o !== 1'b0) begin bad++; $display("FAIL rst_stall got=%b want=0", ifc.stallReq_o); end
        total++; if (ifc.instValid_o !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", ifc.instValid_o); end
        total++; if (ifc.inst_o !== 32'd0) begin bad++; $display("FAIL rst_inst got=%h want=0", ifc.inst_o); end
        total++; if (sram_addr !== 20'd0) begin bad++; $display("FAIL rst_addr got=%h want=0", sram_addr); end
        total++; if ({ce_n, oe_n, we_n, be_n} !== 7'b111_1111) begin bad++; $display("FAIL rst_sram_ctl got=%b want=1111111", {ce_n, oe_n, we_n, be_n}); end
        ifc.ramOp_i = 4'b0000;
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_single_fetch;
        ifc.addr_i = 32'h10; ifc.ramOp_i = 4'b1000; #1;
        total++; if (ifc.stallReq_o !== 1'b1 || ce_n !== 1'b1) begin bad++; $display("FAIL single_c0 stall/ce_n got=%b%b want=11", ifc.stallReq_o, ce_n); end
        tick; ifc.ramOp_i = 4'b0000;
        for (int c = 1; c <= 2; c++) begin
            #1;
            total++;
            if ({ce_n, oe_n, be_n, ifc.stallReq_o, ifc.instValid_o} !== 8'b00_0000_10 || sram_addr !== 20'h4) begin
                bad++;
                $display("FAIL single_access_c%0d ctl got=%b addr=%h want=00000010 addr=00004", c, {ce_n, oe_n, be_n, ifc.stallReq_o, ifc.instValid_o}, sram_addr);
            end
            tick;
        end
        #1;
        total++; if (ifc.instValid_o !== 1'b1 || ifc.inst_o !== 32'h2402_0005) begin bad++; $display("FAIL single_done got vld=%b inst=%h want vld=1 inst=24020005", ifc.instValid_o, ifc.inst_o); end
        total++; if ({ifc.stallReq_o, ce_n, oe_n, be_n} !== 7'b011_1111) begin bad++; $display("FAIL single_done_ctl got=%b want=0111111", {ifc.stallReq_o, ce_n, oe_n, be_n}); end
        tick; #1;
        total++; if (ifc.instValid_o !== 1'b0 || ifc.inst_o !== 32'h2402_0005) begin bad++; $display("FAIL single_after got vld=%b inst=%h want vld=0 inst=24020005", ifc.instValid_o, ifc.inst_o); end
    endtask

    task automatic test_idle_ops;
        logic [3:0] ops [4] = '{4'b0000, 4'b0100, 4'b1001, 4'b0001};
        for (int i = 0; i < 24; i++) begin
            ifc.ramOp_i = (i < 20) ? ops[i / 10] : ops[2 + (i % 2)];
            ifc.addr_i  = 32'h100 + 32'(i * 4);
            #1;
            total++;
            if (ce_n !== 1'b1 || ifc.stallReq_o !== 1'b0 || ifc.instValid_o !== 1'b0) begin
                bad++;
                $display("FAIL idle_op%b_i%0d ce_n/stall/vld got=%b%b%b want=100", ifc.ramOp_i, i, ce_n, ifc.stallReq_o, ifc.instValid_o);
            end
            tick;
        end
        ifc.ramOp_i = 4'b0000;
    endtask

    task automatic test_pc_model;
        logic [31:0] pc = 32'h0;
        logic        stall_prev = 1'b0;
        int          npulse = 0;
        for (int c = 0; c < 20; c++) begin
            ifc.ramOp_i = (!stall_prev && pc < 32'd12) ? 4'b1000 : 4'b0000;
            ifc.addr_i  = pc;
            #1;
            if (ifc.instValid_o === 1'b1) begin
                total++;
                if (ifc.inst_o !== {12'h3C0, 20'(npulse)} || c != 3 + 4 * npulse) begin
                    bad++;
                    $display("FAIL pc_pulse%0d got inst=%h cyc=%0d want inst=%h cyc=%0d", npulse, ifc.inst_o, c, {12'h3C0, 20'(npulse)}, 3 + 4 * npulse);
                end
                npulse++;
                pc = pc + 32'd4;
            end
            stall_prev = ifc.stallReq_o;
            tick;
        end
        total++; if (npulse != 3) begin bad++; $display("FAIL pc_pulse_count got=%0d want=3", npulse); end
        ifc.ramOp_i = 4'b0000;
    endtask

    task automatic test_back_to_back;
        ifc.addr_i = 32'h8; ifc.ramOp_i = 4'b1000;
        for (int c = 0; c < 12; c++) begin
            #1;
            total++;
            if (ifc.instValid_o !== (c % 4 == 3) || ifc.stallReq_o !== (c % 4 != 3)) begin
                bad++;
                $display("FAIL b2b_c%0d vld/stall got=%b%b want=%b%b", c, ifc.instValid_o, ifc.stallReq_o, c % 4 == 3, c % 4 != 3);
            end
            tick;
        end
        ifc.ramOp_i = 4'b0000;
        tick;
    endtask

    task automatic test_reset_mid;
        bit seen = 0;
        ifc.addr_i = 32'h20; ifc.ramOp_i = 4'b1000;
        tick; ifc.ramOp_i = 4'b0000; #1;
        total++; if (ce_n !== 1'b0) begin bad++; $display("FAIL rstmid_access ce_n got=%b want=0", ce_n); end
        rst = 1'b1; #1;
        total++; if (ifc.stallReq_o !== 1'b0) begin bad++; $display("FAIL rstmid_stall_forced got=%b want=0", ifc.stallReq_o); end
        tick; rst = 1'b0; #1;
        total++; if ({ce_n, oe_n, ifc.stallReq_o, ifc.instValid_o} !== 4'b1100 || sram_addr !== 20'd0 || ifc.inst_o !== 32'd0) begin
            bad++; $display("FAIL rstmid_after got ctl=%b addr=%h inst=%h want ctl=1100 addr=0 inst=0", {ce_n, oe_n, ifc.stallReq_o, ifc.instValid_o}, sram_addr, ifc.inst_o);
        end
        for (int c = 0; c < 5; c++) begin
            if (ifc.instValid_o === 1'b1) seen = 1;
            tick;
        end
        total++; if (seen) begin bad++; $display("FAIL rstmid_no_pulse got=1 want=0"); end
        ifc.addr_i = 32'h24; ifc.ramOp_i = 4'b1000;
        tick; ifc.ramOp_i = 4'b0000;
        tick; tick; #1;
        total++; if (ifc.instValid_o !== 1'b1 || ifc.inst_o !== 32'h3C00_0009) begin bad++; $display("FAIL rstmid_refetch got vld=%b inst=%h want vld=1 inst=3c000009", ifc.instValid_o, ifc.inst_o); end
        tick;
    endtask

    task automatic test_addr_change;
        ifc.addr_i = 32'h40; ifc.ramOp_i = 4'b1000;
        tick; ifc.addr_i = 32'hFFFF_FFFC; ifc.ramOp_i = 4'b0000;
        for (int c = 1; c <= 2; c++) begin
            #1;
            total++; if (sram_addr !== 20'h10) begin bad++; $display("FAIL addrchg_c%0d got=%h want=00010", c, sram_addr); end
            tick;
        end
        #1;
        total++; if (ifc.instValid_o !== 1'b1 || ifc.inst_o !== 32'h3C00_0010) begin bad++; $display("FAIL addrchg_data got vld=%b inst=%h want vld=1 inst=3c000010", ifc.instValid_o, ifc.inst_o); end
        tick; ifc.addr_i = 32'h0;
    endtask

    task automatic test_align;
        ifc.addr_i = 32'h6; ifc.ramOp_i = 4'b1000; #1;
        total++; if (ifc.stallReq_o !== 1'b1 || ce_n !== 1'b1) begin bad++; $display("FAIL align_c0 stall/ce_n got=%b%b want=11", ifc.stallReq_o, ce_n); end
        tick; ifc.ramOp_i = 4'b0000;
`ifdef FETCH_ALIGN_CHECK_EN
        #1;
        total++; if ({ifc.instValid_o, exc, ce_n, ifc.stallReq_o} !== 4'b1110 || ifc.inst_o !== 32'd0) begin
            bad++; $display("FAIL align_exc got vld/exc/ce_n/stall=%b inst=%h want 1110 inst=0", {ifc.instValid_o, exc, ce_n, ifc.stallReq_o}, ifc.inst_o);
        end
        tick; #1;
        total++; if (ifc.instValid_o !== 1'b0 || exc !== 1'b0) begin bad++; $display("FAIL align_after got vld/exc=%b%b want=00", ifc.instValid_o, exc); end
`else
        #1;
        total++; if (ce_n !== 1'b0 || sram_addr !== 20'h1) begin bad++; $display("FAIL align_off_access got ce_n=%b addr=%h want 0 00001", ce_n, sram_addr); end
        tick; tick; #1;
        total++; if (ifc.instValid_o !== 1'b1 || ifc.inst_o !== 32'h3C00_0001) begin bad++; $display("FAIL align_off_data got vld=%b inst=%h want vld=1 inst=3c000001", ifc.instValid_o, ifc.inst_o); end
`endif
        tick;
    endtask

    initial begin
        ifc.addr_i  = 32'h0;
        ifc.ramOp_i = 4'b0000;
        test_reset;
        test_single_fetch;
        test_idle_ops;
        test_pc_model;
        test_back_to_back;
        test_reset_mid;
        test_addr_change;
        test_align;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
